// File: rtl/dmac_xfer_seq.sv
// DMAC channel-0 transfer sequencer.
// Moves data in bursts from the source into the 16-word buffer over AHB reads,
// then out to the destination over AHB writes. It repeats until the remaining
// transfer size runs out, then disables the channel and raises the completion
// interrupt. The register bank owns every address, counter and flag; this block
// only drives the pulses that update them.
module dmac_xfer_seq #(
  parameter int MAX_BEATS = 16,
  parameter int ADDR_W    = 32
) (
  input  logic        r_HCLK,
  input  logic        r_HRESET,
  input  logic        CHANNEL_enable,
  input  logic [11:0] TS,
  input  logic [2:0]  BS,
  input  logic        sync_grant,
  input  logic        m_HREADY,
  output logic        m_HBUSREQ,
  output logic [1:0]  m_HTRANS,
  output logic        m_HWRITE,
  output logic [2:0]  m_HBURST,
  output logic        buf_wr_en,
  output logic        load_DMAC_C0_Addr,
  output logic        src_addr_inc,
  output logic        dest_addr_inc,
  output logic        src_burst_zero_flag,
  output logic        dest_burst_zero_flag,
  output logic        buffer_idx_inc,
  output logic        buffer_zero_flag,
  output logic        TransferSize_dec_flag,
  output logic        CHANNEL_dis_flag,
  output logic        set_DMACINTR_pend,
  output logic        busy
);

  // The bank generates the addresses, so the width is carried only for integration.
  localparam int ADDR_W_UNUSED = ADDR_W;
  localparam logic [4:0] MAX_BEATS_C = 5'(MAX_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_RD   = 3'd3,
    ST_WSET = 3'd4,
    ST_WR   = 3'd5,
    ST_CHK  = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] beat_tot_q, beat_tot_d;
  logic [4:0] addr_cnt_q, addr_cnt_d;
  logic [4:0] data_cnt_q, data_cnt_d;
  logic       dp_q, dp_d;
  logic       nonseq_q, nonseq_d;

  logic [9:0] words_s;
  logic [4:0] bl_raw_s;
  logic [4:0] bl_s;
  logic [4:0] beats_s;
  logic       addr_pend_s;
  logic       addr_acc_s;
  logic       data_done_s;
  logic       is_wr_s;
  logic       ts_lsb_unused_s;

  // The transfer size is counted in bytes, but the data moves as whole words.
  assign words_s         = TS[11:2];
  assign ts_lsb_unused_s = ^TS[1:0];
  assign addr_pend_s     = (addr_cnt_q < beat_tot_q);
  assign busy            = (state_q != ST_IDLE);

  // Decode the burst length from BS and clamp it to the buffer depth and to the words left.
  always_comb begin
    case (BS)
      3'd0:    bl_raw_s = 5'd1;
      3'd1:    bl_raw_s = 5'd4;
      3'd2:    bl_raw_s = 5'd8;
      default: bl_raw_s = 5'd16;
    endcase
    if (bl_raw_s > MAX_BEATS_C) begin
      bl_s = MAX_BEATS_C;
    end else begin
      bl_s = bl_raw_s;
    end
    if ({5'd0, bl_s} > words_s) begin
      beats_s = words_s[4:0];
    end else begin
      beats_s = bl_s;
    end
  end

  // Compute the next state, the AHB address/data pipeline and the register-bank pulses.
  always_comb begin
    state_d               = state_q;
    beat_tot_d            = beat_tot_q;
    addr_cnt_d            = addr_cnt_q;
    data_cnt_d            = data_cnt_q;
    dp_d                  = dp_q;
    nonseq_d              = nonseq_q;
    m_HBUSREQ             = 1'b0;
    m_HTRANS              = 2'd0;
    m_HWRITE              = 1'b0;
    m_HBURST              = 3'd0;
    buf_wr_en             = 1'b0;
    load_DMAC_C0_Addr     = 1'b0;
    src_addr_inc          = 1'b0;
    dest_addr_inc         = 1'b0;
    src_burst_zero_flag   = 1'b0;
    dest_burst_zero_flag  = 1'b0;
    buffer_idx_inc        = 1'b0;
    buffer_zero_flag      = 1'b0;
    TransferSize_dec_flag = 1'b0;
    CHANNEL_dis_flag      = 1'b0;
    set_DMACINTR_pend     = 1'b0;
    is_wr_s               = (state_q == ST_WR);
    addr_acc_s            = 1'b0;
    data_done_s           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CHANNEL_enable) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        load_DMAC_C0_Addr    = 1'b1;
        src_burst_zero_flag  = 1'b1;
        dest_burst_zero_flag = 1'b1;
        buffer_zero_flag     = 1'b1;
        if (words_s == 10'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_REQ;
          beat_tot_d = beats_s;
        end
      end

      ST_REQ: begin
        m_HBUSREQ = 1'b1;
        if (sync_grant) begin
          state_d    = ST_RD;
          addr_cnt_d = 5'd0;
          data_cnt_d = 5'd0;
          dp_d       = 1'b0;
          nonseq_d   = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_RD, ST_WR: begin
        m_HBUSREQ = 1'b1;
        m_HWRITE  = is_wr_s;
        m_HBURST  = (beat_tot_q == 5'd1) ? 3'd0 : 3'd1;
        if (addr_pend_s && sync_grant) begin
          m_HTRANS = nonseq_q ? 2'd2 : 2'd3;
        end else begin
          m_HTRANS = 2'd0;
        end
        addr_acc_s  = addr_pend_s && sync_grant && m_HREADY;
        data_done_s = dp_q && m_HREADY;

        // Address phase: a lost grant forces the next accepted beat to restart as NONSEQ.
        if (addr_acc_s) begin
          addr_cnt_d    = addr_cnt_q + 5'd1;
          nonseq_d      = 1'b0;
          src_addr_inc  = ~is_wr_s;
          dest_addr_inc = is_wr_s;
        end else if (!sync_grant) begin
          nonseq_d = 1'b1;
        end else begin
          nonseq_d = nonseq_q;
        end

        // Data phase: reads land in the buffer, writes consume a word of the transfer size.
        if (data_done_s) begin
          data_cnt_d            = data_cnt_q + 5'd1;
          buffer_idx_inc        = 1'b1;
          buf_wr_en             = ~is_wr_s;
          TransferSize_dec_flag = is_wr_s;
        end else begin
          data_cnt_d = data_cnt_q;
        end

        if (addr_acc_s) begin
          dp_d = 1'b1;
        end else if (data_done_s) begin
          dp_d = 1'b0;
        end else begin
          dp_d = dp_q;
        end

        if (data_cnt_q == beat_tot_q) begin
          state_d = is_wr_s ? ST_CHK : ST_WSET;
        end else begin
          state_d = state_q;
        end
      end

      ST_WSET: begin
        m_HBUSREQ           = 1'b1;
        buffer_zero_flag    = 1'b1;
        src_burst_zero_flag = 1'b1;
        addr_cnt_d          = 5'd0;
        data_cnt_d          = 5'd0;
        dp_d                = 1'b0;
        nonseq_d            = 1'b1;
        state_d             = ST_WR;
      end

      ST_CHK: begin
        dest_burst_zero_flag = 1'b1;
        buffer_zero_flag     = 1'b1;
        if (words_s == 10'd0) begin
          state_d = ST_DONE;
        end else if (!CHANNEL_enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_REQ;
          beat_tot_d = beats_s;
        end
      end

      ST_DONE: begin
        CHANNEL_dis_flag  = 1'b1;
        set_DMACINTR_pend = 1'b1;
        state_d           = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and burst counters; reset abandons any burst in flight.
  always_ff @(posedge r_HCLK or posedge r_HRESET) begin
    if (r_HRESET) begin
      state_q    <= ST_IDLE;
      beat_tot_q <= 5'd0;
      addr_cnt_q <= 5'd0;
      data_cnt_q <= 5'd0;
      dp_q       <= 1'b0;
      nonseq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_tot_q <= beat_tot_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
      dp_q       <= dp_d;
      nonseq_q   <= nonseq_d;
    end
  end

endmodule

// File: tb/tb_dmac_xfer_seq.sv
// Directed bench for dmac_xfer_seq. The bench also stands in for the register
// bank: it applies TS decrements and clears the channel enable when the DUT asks.
module tb_dmac_xfer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] ts;
  logic [2:0]  bs;
  logic        grant;
  logic        hready;

  logic        m_HBUSREQ, m_HWRITE, buf_wr_en, load_DMAC_C0_Addr;
  logic [1:0]  m_HTRANS;
  logic [2:0]  m_HBURST;
  logic        src_addr_inc, dest_addr_inc, src_burst_zero_flag, dest_burst_zero_flag;
  logic        buffer_idx_inc, buffer_zero_flag, TransferSize_dec_flag;
  logic        CHANNEL_dis_flag, set_DMACINTR_pend, busy;
  logic [18:0] all_out;

  always #5 clk = ~clk;

  dmac_xfer_seq #(.MAX_BEATS(16), .ADDR_W(32)) dut (
    .r_HCLK(clk), .r_HRESET(rst), .CHANNEL_enable(en), .TS(ts), .BS(bs),
    .sync_grant(grant), .m_HREADY(hready), .m_HBUSREQ(m_HBUSREQ), .m_HTRANS(m_HTRANS),
    .m_HWRITE(m_HWRITE), .m_HBURST(m_HBURST), .buf_wr_en(buf_wr_en),
    .load_DMAC_C0_Addr(load_DMAC_C0_Addr), .src_addr_inc(src_addr_inc),
    .dest_addr_inc(dest_addr_inc), .src_burst_zero_flag(src_burst_zero_flag),
    .dest_burst_zero_flag(dest_burst_zero_flag), .buffer_idx_inc(buffer_idx_inc),
    .buffer_zero_flag(buffer_zero_flag), .TransferSize_dec_flag(TransferSize_dec_flag),
    .CHANNEL_dis_flag(CHANNEL_dis_flag), .set_DMACINTR_pend(set_DMACINTR_pend), .busy(busy)
  );

  assign all_out = {m_HBUSREQ, m_HTRANS, m_HWRITE, m_HBURST, buf_wr_en, load_DMAC_C0_Addr,
                    src_addr_inc, dest_addr_inc, src_burst_zero_flag, dest_burst_zero_flag,
                    buffer_idx_inc, buffer_zero_flag, TransferSize_dec_flag,
                    CHANNEL_dis_flag, set_DMACINTR_pend, busy};

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_src, n_dest, n_bufwr, n_bufidx, n_tsdec, n_dis, n_intr, n_load;
  int n_rd_ns, n_rd_seq, n_wr_ns, n_wr_seq, n_single, n_hbr_rise, n_busy_gap;
  int rd_beat, rd9_trans, chk_cyc, intr_cyc;
  int mode, hr_left, gr_left;
  logic hr_fired, gr_fired, prev_hbr, seen_busy;
  logic s_busy, s_load;
  int   s_all;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_src = 0; n_dest = 0; n_bufwr = 0; n_bufidx = 0; n_tsdec = 0; n_dis = 0;
    n_intr = 0; n_load = 0; n_rd_ns = 0; n_rd_seq = 0; n_wr_ns = 0; n_wr_seq = 0;
    n_single = 0; n_hbr_rise = 0; n_busy_gap = 0; rd_beat = 0; rd9_trans = -1;
    chk_cyc = -100; intr_cyc = -1; mode = 0; hr_left = 0; gr_left = 0;
    hr_fired = 1'b0; gr_fired = 1'b0; prev_hbr = 1'b0; seen_busy = 1'b0;
  endtask

  // One clock: sample on the falling edge, then act as the register bank and
  // apply any scripted stalls just after the rising edge.
  task automatic tick();
    logic acc, dec, dis;
    @(negedge clk);
    #1;
    s_busy = busy;
    s_load = load_DMAC_C0_Addr;
    s_all  = int'(all_out);
    acc = hready && grant && (m_HTRANS != 2'd0);
    if (acc) begin
      if (m_HBURST == 3'd0) n_single++;
      if (!m_HWRITE) begin
        rd_beat++;
        if (rd_beat == 9) rd9_trans = int'(m_HTRANS);
        if (m_HTRANS == 2'd2) n_rd_ns++; else n_rd_seq++;
      end else begin
        if (m_HTRANS == 2'd2) n_wr_ns++; else n_wr_seq++;
      end
    end
    n_src    += int'(src_addr_inc);
    n_dest   += int'(dest_addr_inc);
    n_bufwr  += int'(buf_wr_en);
    n_bufidx += int'(buffer_idx_inc);
    n_tsdec  += int'(TransferSize_dec_flag);
    n_dis    += int'(CHANNEL_dis_flag);
    n_load   += int'(load_DMAC_C0_Addr);
    if (m_HBUSREQ && !prev_hbr) n_hbr_rise++;
    prev_hbr = m_HBUSREQ;
    if (dest_burst_zero_flag && !load_DMAC_C0_Addr) chk_cyc = cyc;
    if (busy) seen_busy = 1'b1;
    else if (seen_busy && n_intr == 0) n_busy_gap++;
    if (set_DMACINTR_pend) begin
      n_intr++;
      intr_cyc = cyc;
    end
    dec = TransferSize_dec_flag;
    dis = CHANNEL_dis_flag;
    @(posedge clk);
    #1;
    cyc++;
    if (dec) ts = ts - 12'd4;
    if (dis) en = 1'b0;
    if (hr_left > 0) begin
      hr_left--;
      if (hr_left == 0) hready = 1'b1;
    end else if (mode == 1 && n_src == 4 && !hr_fired) begin
      hr_fired = 1'b1; hready = 1'b0; hr_left = 2;
    end
    if (gr_left > 0) begin
      gr_left--;
      if (gr_left == 0) grant = 1'b1;
    end else if (mode == 1 && n_src == 8 && !gr_fired) begin
      gr_fired = 1'b1; grant = 1'b0; gr_left = 3;
    end
    if (mode == 2 && n_src >= 2) en = 1'b0;
  endtask

  // Clock until the sequencer has been busy and has returned to idle, within a bound.
  task automatic run_xfer(input string tag, input int limit);
    logic seen, fin;
    seen = 1'b0;
    fin  = 1'b0;
    for (int k = 0; k < limit && !fin; k++) begin
      tick();
      if (s_busy) seen = 1'b1;
      else if (seen) fin = 1'b1;
    end
    check_eq({tag, "_finished"}, int'(fin), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ts = 12'h010; bs = 3'd1; grant = 1'b1; hready = 1'b1;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    tick();
    check_eq("reset_outputs", s_all, 0);

    // 4-word transfer with BS=1: a single 4-beat burst.
    rst = 1'b0;
    clear_counts();
    run_xfer("t1", 200);
    check_eq("t1_load", n_load, 1);
    check_eq("t1_src_inc", n_src, 4);
    check_eq("t1_buf_wr", n_bufwr, 4);
    check_eq("t1_buf_idx", n_bufidx, 8);
    check_eq("t1_dest_inc", n_dest, 4);
    check_eq("t1_ts_dec", n_tsdec, 4);
    check_eq("t1_rd_nonseq", n_rd_ns, 1);
    check_eq("t1_rd_seq", n_rd_seq, 3);
    check_eq("t1_wr_nonseq", n_wr_ns, 1);
    check_eq("t1_wr_seq", n_wr_seq, 3);
    check_eq("t1_single", n_single, 0);
    check_eq("t1_dis", n_dis, 1);
    check_eq("t1_intr", n_intr, 1);
    check_eq("t1_busy_gap", n_busy_gap, 0);
    check_eq("t1_ts_final", int'(ts), 0);

    // 10 words with BS=2: an 8-beat burst, then a shortened 2-beat burst.
    clear_counts();
    ts = 12'h028; bs = 3'd2; en = 1'b1;
    run_xfer("t2", 300);
    check_eq("t2_src_inc", n_src, 10);
    check_eq("t2_dest_inc", n_dest, 10);
    check_eq("t2_buf_wr", n_bufwr, 10);
    check_eq("t2_ts_dec", n_tsdec, 10);
    check_eq("t2_busreq_rises", n_hbr_rise, 2);
    check_eq("t2_intr", n_intr, 1);

    // One word with BS=0: SINGLE bursts, NONSEQ only.
    clear_counts();
    ts = 12'h004; bs = 3'd0; en = 1'b1;
    run_xfer("t3", 100);
    check_eq("t3_single", n_single, 2);
    check_eq("t3_rd_nonseq", n_rd_ns, 1);
    check_eq("t3_wr_nonseq", n_wr_ns, 1);
    check_eq("t3_seq", n_rd_seq + n_wr_seq, 0);
    check_eq("t3_intr_after_chk", intr_cyc - chk_cyc, 1);
    check_eq("t3_intr", n_intr, 1);

    // 16 beats with wait states on beat 5 and a 3-cycle grant loss before beat 9.
    clear_counts();
    ts = 12'h040; bs = 3'd3; en = 1'b1; mode = 1;
    run_xfer("t4", 400);
    check_eq("t4_src_inc", n_src, 16);
    check_eq("t4_buf_wr", n_bufwr, 16);
    check_eq("t4_rd_nonseq", n_rd_ns, 2);
    check_eq("t4_rd_seq", n_rd_seq, 14);
    check_eq("t4_beat9_trans", rd9_trans, 2);
    check_eq("t4_dest_inc", n_dest, 16);
    check_eq("t4_intr", n_intr, 1);

    // Channel disabled during the first burst: that burst finishes and the channel aborts.
    clear_counts();
    ts = 12'h080; bs = 3'd1; en = 1'b1; mode = 2;
    run_xfer("t5", 300);
    check_eq("t5_src_inc", n_src, 4);
    check_eq("t5_dest_inc", n_dest, 4);
    check_eq("t5_ts_dec", n_tsdec, 4);
    check_eq("t5_ts_left", int'(ts), 112);
    check_eq("t5_intr", n_intr, 0);
    check_eq("t5_dis", n_dis, 0);

    // Reset hits during a write burst; the enable is still high when reset releases.
    clear_counts();
    ts = 12'h040; bs = 3'd3; en = 1'b1;
    for (int k = 0; k < 400 && n_dest < 3; k++) tick();
    check_eq("t6_in_write", n_dest, 3);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_outputs", s_all, 0);
    rst = 1'b0;
    tick();
    check_eq("t6_idle_after_rst", int'(s_busy), 0);
    tick();
    check_eq("t6_reload", int'(s_load), 1);
    clear_counts();
    run_xfer("t6", 400);
    check_eq("t6_intr", n_intr, 1);
    check_eq("t6_ts_final", int'(ts), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_xfer_seq.md
Name: dmac_xfer_seq

Overview:
Channel-0 transfer sequencer for the DMAC; sits between the DMAC register bank and the AHB master port.
- Reads a burst from the source into the 16-word DMAC buffer, then writes it to the destination.
- Repeats until the transfer size is exhausted, then disables the channel and flags completion.
- Drives all counter/flag controls of the register bank: address load/increment, burst counters, buffer index and transfer-size decrement.

Parameters:
MAX_BEATS, 16, buffer depth in words; upper bound on beats per burst
ADDR_W, 32, AHB address width

Ports:
r_HCLK  in  1  system clock
r_HRESET  in  1  asynchronous reset, active-high
CHANNEL_enable  in  1  channel enable from register bank
TS  in  12  remaining transfer size in bytes (bank decrements it by 4 per pulse)
BS  in  3  burst-size code
sync_grant  in  1  registered HGRANT from register bank
m_HREADY  in  1  AHB HREADY
m_HBUSREQ  out  1  bus request
m_HTRANS  out  2  0=IDLE, 2=NONSEQ, 3=SEQ
m_HWRITE  out  1  1 during write bursts
m_HBURST  out  3  0=SINGLE (1 beat), 1=INCR (more than 1 beat)
buf_wr_en  out  1  capture HRDATA into buffer[dmac_buffer_idx]
load_DMAC_C0_Addr  out  1  load master address copies
src_addr_inc, dest_addr_inc  out  1 each  address/burst-counter increment
src_burst_zero_flag, dest_burst_zero_flag  out  1 each  clear burst counters
buffer_idx_inc, buffer_zero_flag  out  1 each  buffer index control
TransferSize_dec_flag  out  1  TS -= 4 request
CHANNEL_dis_flag  out  1  clear channel enable
set_DMACINTR_pend  out  1  completion pulse
busy  out  1  state != IDLE

Behaviour:
Reset and output defaults:
- All outputs 0 on reset; state=IDLE; internal counters 0. Reset mid-burst aborts immediately: HTRANS=IDLE and HBUSREQ=0 on the next cycle.
- All flags are single-cycle pulses unless stated otherwise.

Burst length and beat count:
- Burst length BL from BS: 0→1, 1→4, 2→8, 3–7→16 (clamped to MAX_BEATS).
- words = TS[11:2]; TS[1:0] is ignored.
- beats = min(BL, words), latched on entry to REQ into beat_tot (5 bits).

States:
- IDLE: if CHANNEL_enable=1 → LOAD.
- LOAD (1 cycle): pulse load_DMAC_C0_Addr, src_burst_zero_flag, dest_burst_zero_flag, buffer_zero_flag. If words=0 → DONE, else → REQ.
- REQ: m_HBUSREQ=1 (held through RD and WR). On sync_grant=1 → RD with addr_cnt=0 and data_cnt=0.
- RD: address phases.
  - HTRANS = NONSEQ for the first beat or the first beat after a stall; otherwise SEQ.
  - An address is accepted when m_HREADY=1 and sync_grant=1. On acceptance, pulse src_addr_inc and increment addr_cnt.
  - Data-phase pending flag dp is set for the cycle after acceptance. When dp=1 and m_HREADY=1, pulse buf_wr_en and buffer_idx_inc together, and increment data_cnt.
  - After the final address is accepted: HTRANS=IDLE, stay until data_cnt=beat_tot, then → WSET.
- WSET (1 cycle): pulse buffer_zero_flag, src_burst_zero_flag.
- WR: same address/data pipeline with m_HWRITE=1.
  - On address acceptance: pulse dest_addr_inc.
  - On write data-phase completion: pulse buffer_idx_inc and TransferSize_dec_flag.
  - When data_cnt=beat_tot → CHK.
- CHK (1 cycle):
  - m_HBUSREQ=0; pulse dest_burst_zero_flag and buffer_zero_flag.
  - Evaluated using the TS value already updated by the register bank.
  - If TS[11:2]=0 → DONE.
  - Else if CHANNEL_enable=0 → IDLE (abort; no interrupt, no CHANNEL_dis_flag).
  - Else → REQ.
- DONE (1 cycle): pulse CHANNEL_dis_flag and set_DMACINTR_pend → IDLE.

Grant and wait states:
- If sync_grant=0 while in RD/WR: no new address is issued, HTRANS=IDLE, and any pending data phase still completes on HREADY. The next address after grant returns uses NONSEQ.
- m_HREADY=0 stretches the cycle: outputs hold, no pulses are issued.

Boundaries:
- A single-word burst uses HBURST=SINGLE and NONSEQ only.
- words < BL on the final burst gives a shortened burst.
- CHANNEL_enable falling mid-burst has no effect until CHK.
- CHANNEL_enable held high after DONE starts a new transfer only once the bank has cleared it and software re-enables it.

Test Plan:
- TS=0x010, BS=1, grant immediate, HREADY=1 → one read burst of 4 beats (NONSEQ,SEQ,SEQ,SEQ), 4 buf_wr_en, then 4 write beats, 4 TransferSize_dec_flag, then CHANNEL_dis_flag and set_DMACINTR_pend each once; busy high throughout.
- TS=0x028, BS=2 → bursts of 8 then 2 words; 10 src_addr_inc total, 10 dest_addr_inc total; m_HBUSREQ drops in CHK between the bursts.
- TS=0x004, BS=0 → HBURST=SINGLE, one NONSEQ read and one NONSEQ write; interrupt pulse 1 cycle after CHK.
- BS=3, TS=0x040, HREADY low 2 cycles on beat 5, grant removed 3 cycles on beat 9 → no extra increments, 16 buf_wr_en, beat 9 reissued as NONSEQ.
- CHANNEL_enable deasserted mid-burst with TS=0x080, BS=1 → current burst completes, CHK → IDLE, no set_DMACINTR_pend.
- r_HRESET asserted during a WR burst → next cycle all outputs 0 and state IDLE; after release, LOAD re-entered if CHANNEL_enable=1.
